clint_timer: RTL and testbench



---
 rtl/clint_timer_if.sv | 20 ++
 rtl/clint_timer.sv | 118 +++++++++++
 tb/tb_clint_timer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/clint_timer_if.sv
// Data-memory-side register bus for the machine timer: select, strobes, word
// address and data, as driven by the MEM-WB stage and address decoder.
interface clint_timer_if;
  logic        sel;
  logic        rd_en;
  logic        wr_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, rd_en, wr_en, addr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, rd_en, wr_en, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, CTRL/STATUS,
// latched high-half read shadow and a registered level timer interrupt.
module clint_timer #(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] RST_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  clint_timer_if.slave  bus,
  output logic          timer_interrupt
);

  localparam logic [2:0]  R_MTIME_LO = 3'd0;
  localparam logic [2:0]  R_MTIME_HI = 3'd1;
  localparam logic [2:0]  R_CMP_LO   = 3'd2;
  localparam logic [2:0]  R_CMP_HI   = 3'd3;
  localparam logic [2:0]  R_CTRL     = 3'd4;
  localparam logic [2:0]  R_STATUS   = 3'd5;
  localparam logic [15:0] PS_MAX     = 16'(PRESCALE - 1);

  logic [63:0] mtime, mtime_nxt;
  logic [63:0] mtimecmp, mtimecmp_nxt;
  logic [15:0] pcnt, pcnt_nxt;
  logic [31:0] hi_shadow, hi_shadow_nxt;
  logic        en, en_nxt;
  logic        ie, ie_nxt;
  logic        irq_nxt;
  logic        tick;
  logic        rd, wr;
  logic        pend;
  logic [2:0]  reg_idx;
  logic [1:0]  unused_addr_lsb;

  assign reg_idx         = bus.addr[4:2];
  assign unused_addr_lsb = bus.addr[1:0];
  assign rd              = bus.sel && bus.rd_en;
  assign wr              = bus.sel && bus.wr_en;
  assign tick            = en && (pcnt == PS_MAX);
  assign pend            = (mtime >= mtimecmp);

  always_comb begin
    pcnt_nxt      = pcnt;
    mtime_nxt     = mtime;
    mtimecmp_nxt  = mtimecmp;
    en_nxt        = en;
    ie_nxt        = ie;
    hi_shadow_nxt = hi_shadow;

    if (en) begin
      pcnt_nxt = tick ? 16'd0 : pcnt + 16'd1;
    end
    if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
    if (rd && (reg_idx == R_MTIME_LO)) begin
      hi_shadow_nxt = mtime[63:32];
    end

    // A software write to either mtime half wins over this cycle's increment.
    if (wr) begin
      case (reg_idx)
        R_MTIME_LO: begin
          mtime_nxt = {mtime[63:32], bus.wdata};
          pcnt_nxt  = 16'd0;
        end
        R_MTIME_HI: begin
          mtime_nxt = {bus.wdata, mtime[31:0]};
          pcnt_nxt  = 16'd0;
        end
        R_CMP_LO: mtimecmp_nxt = {mtimecmp[63:32], bus.wdata};
        R_CMP_HI: mtimecmp_nxt = {bus.wdata, mtimecmp[31:0]};
        R_CTRL: begin
          en_nxt = bus.wdata[0];
          ie_nxt = bus.wdata[1];
        end
        default: ;
      endcase
    end

    irq_nxt = ie_nxt && (mtime_nxt >= mtimecmp_nxt);
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (rd) begin
      case (reg_idx)
        R_MTIME_LO: bus.rdata = mtime[31:0];
        R_MTIME_HI: bus.rdata = hi_shadow;
        R_CMP_LO:   bus.rdata = mtimecmp[31:0];
        R_CMP_HI:   bus.rdata = mtimecmp[63:32];
        R_CTRL:     bus.rdata = {30'd0, ie, en};
        R_STATUS:   bus.rdata = {31'd0, pend};
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime           <= 64'd0;
      mtimecmp        <= RST_MTIMECMP;
      pcnt            <= 16'd0;
      hi_shadow       <= 32'd0;
      en              <= 1'b0;
      ie              <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      mtime           <= mtime_nxt;
      mtimecmp        <= mtimecmp_nxt;
      pcnt            <= pcnt_nxt;
      hi_shadow       <= hi_shadow_nxt;
      en              <= en_nxt;
      ie              <= ie_nxt;
      timer_interrupt <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer: instance A uses PRESCALE=1,
// instance B uses PRESCALE=4; both share clk and rst.
module tb_clint_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_a, irq_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  clint_timer_if if_a ();
  clint_timer_if if_b ();

  clint_timer #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .timer_interrupt(irq_a)
  );

  clint_timer #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .timer_interrupt(irq_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    if_a.sel = 1'b0; if_a.rd_en = 1'b0; if_a.wr_en = 1'b0; if_a.addr = 5'd0; if_a.wdata = 32'd0;
    if_b.sel = 1'b0; if_b.rd_en = 1'b0; if_b.wr_en = 1'b0; if_b.addr = 5'd0; if_b.wdata = 32'd0;
  endtask

  // One bus cycle: drive at negedge, sample rdata combinationally, consume one posedge.
  task automatic bus_access(input bit b, input int idx, input bit do_rd, input bit do_wr,
                            input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    if (b) begin
      if_b.sel = 1'b1; if_b.rd_en = do_rd; if_b.wr_en = do_wr; if_b.addr = 5'(idx * 4); if_b.wdata = d;
    end else begin
      if_a.sel = 1'b1; if_a.rd_en = do_rd; if_a.wr_en = do_wr; if_a.addr = 5'(idx * 4); if_a.wdata = d;
    end
    #1;
    q = b ? if_b.rdata : if_a.rdata;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_write(input bit b, input int idx, input logic [31:0] d);
    logic [31:0] q;
    bus_access(b, idx, 1'b0, 1'b1, d, q);
  endtask

  task automatic bus_read(input bit b, input int idx, output logic [31:0] q);
    bus_access(b, idx, 1'b1, 1'b0, 32'd0, q);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL rst_irq_a: got %b expected 0", irq_a); end
    n_checks++; if (irq_b !== 1'b0) begin n_fail++; $display("FAIL rst_irq_b: got %b expected 0", irq_b); end
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mtime_lo: got %h expected 0", v); end
    bus_read(0, 1, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mtime_hi: got %h expected 0", v); end
    bus_read(0, 2, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_lo: got %h expected ffffffff", v); end
    bus_read(0, 3, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_cmp_hi: got %h expected ffffffff", v); end
    bus_read(0, 4, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 0", v); end
    bus_read(0, 5, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %h expected 0", v); end

    // Reserved bits and read-only/unmapped registers ignore writes.
    bus_write(0, 4, 32'hFFFF_FFFE);
    bus_read(0, 4, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL ctrl_reserved: got %h expected 2", v); end
    bus_write(0, 4, 32'd0);
    bus_write(0, 5, 32'hFFFF_FFFF);
    bus_read(0, 5, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL status_ro: got %h expected 0", v); end
    bus_write(0, 7, 32'hFFFF_FFFF);
    bus_read(0, 7, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reg7_zero: got %h expected 0", v); end

    // Mid-count asynchronous reset.
    bus_write(0, 4, 32'd1);
    repeat (37) @(posedge clk);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd37) begin n_fail++; $display("FAIL count_to_37: got %0d expected 37", v); end
    rst = 1'b1;
    #1;
    if_a.sel = 1'b1; if_a.rd_en = 1'b1; if_a.addr = 5'd0;
    #1;
    n_checks++; if (if_a.rdata !== 32'd0) begin n_fail++; $display("FAIL async_rst_mtime: got %h expected 0", if_a.rdata); end
    if_a.addr = 5'd16;
    #1;
    n_checks++; if (if_a.rdata !== 32'd0) begin n_fail++; $display("FAIL async_rst_ctrl: got %h expected 0", if_a.rdata); end
    if_a.addr = 5'd8;
    #1;
    n_checks++; if (if_a.rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_rst_cmp: got %h expected ffffffff", if_a.rdata); end
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_no_count: got %0d expected 0", v); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    bus_write(1, 4, 32'd1);
    repeat (40) @(posedge clk);
    bus_read(1, 0, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL prescale_40: got %0d expected 10", v); end
    bus_write(1, 4, 32'd0);
    repeat (20) @(posedge clk);
    bus_read(1, 0, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL prescale_hold: got %0d expected 10", v); end
  endtask

  task automatic test_carry_wrap();
    logic [31:0] v;
    bus_write(0, 1, 32'd0);
    bus_write(0, 0, 32'hFFFF_FFFE);
    bus_write(0, 4, 32'd1);
    repeat (2) @(posedge clk);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL carry_lo: got %h expected 0", v); end
    bus_read(0, 1, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL carry_hi: got %h expected 1", v); end
    bus_write(0, 1, 32'hFFFF_FFFF);
    bus_write(0, 0, 32'hFFFF_FFFF);
    @(posedge clk);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_lo: got %h expected 0", v); end
    bus_read(0, 1, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL wrap_hi: got %h expected 0", v); end
    bus_write(0, 4, 32'd0);
  endtask

  task automatic test_atomic_read();
    logic [31:0] v;
    bus_write(0, 1, 32'd1);
    bus_write(0, 0, 32'hFFFF_FFFF);
    bus_write(0, 4, 32'd1);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL atomic_lo: got %h expected ffffffff", v); end
    bus_read(0, 1, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL atomic_hi_shadow: got %h expected 1", v); end
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL atomic_lo2: got %h expected 1", v); end
    bus_read(0, 1, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL atomic_hi2: got %h expected 2", v); end
    bus_write(0, 4, 32'd0);
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    bus_write(0, 1, 32'd0);
    bus_write(0, 0, 32'd0);
    bus_write(0, 3, 32'd0);
    bus_write(0, 2, 32'd100);
    bus_write(0, 4, 32'd3);
    repeat (99) @(posedge clk);
    #1;
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_at_99: got %b expected 0", irq_a); end
    @(posedge clk);
    #1;
    n_checks++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_at_100: got %b expected 1", irq_a); end
    bus_write(0, 2, 32'd200);
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_cmp_raise: got %b expected 0", irq_a); end
    bus_write(0, 4, 32'd1);
    bus_write(0, 2, 32'd0);
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_ie_off: got %b expected 0", irq_a); end
    bus_read(0, 5, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL status_pend: got %h expected 1", v); end
    bus_write(0, 4, 32'd3);
    n_checks++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_ie_on: got %b expected 1", irq_a); end
    bus_write(0, 4, 32'd1);
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_ie_clear: got %b expected 0", irq_a); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    // Instance A is still counting every cycle.
    bus_write(0, 0, 32'd5);
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL collide_a: got %0d expected 5", v); end
    bus_access(0, 0, 1'b1, 1'b1, 32'd100, v);
    n_checks++; if (v !== 32'd6) begin n_fail++; $display("FAIL rw_old_value: got %0d expected 6", v); end
    bus_read(0, 0, v);
    n_checks++; if (v !== 32'd100) begin n_fail++; $display("FAIL rw_new_value: got %0d expected 100", v); end

    // Instance B: write lands on an increment edge, then mid-phase to show restart.
    bus_write(1, 0, 32'd0);
    bus_write(1, 4, 32'd1);
    repeat (3) @(posedge clk);
    bus_write(1, 0, 32'd5);
    bus_read(1, 0, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL collide_b: got %0d expected 5", v); end
    bus_write(1, 0, 32'd20);
    repeat (3) @(posedge clk);
    bus_read(1, 0, v);
    n_checks++; if (v !== 32'd20) begin n_fail++; $display("FAIL prescale_restart: got %0d expected 20", v); end
    bus_read(1, 0, v);
    n_checks++; if (v !== 32'd21) begin n_fail++; $display("FAIL prescale_after: got %0d expected 21", v); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_prescale();
    test_carry_wrap();
    test_atomic_read();
    test_interrupt();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
